// File: rtl/traffic_light_intersection.sv
// traffic_light_intersection
//   Two-road (NS/EW) intersection controller. Green, yellow and all-red
//   phases are timed in tick_en strobes from an external prescaler. Each
//   change of right-of-way passes through an all-red clearance interval.
//   Optional feature macro: TLC_PED_EN adds a pedestrian WALK phase. WALK
//   is entered from ALL_RED when a pedestrian request is pending.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   tick_en    in   1-cycle timing strobe; the timer only moves on these cycles
//   ped_req    in   pedestrian request (level or pulse); ignored without TLC_PED_EN
//   ns_*/ew_*  out  lamp drives per direction (red/yellow/green)
//   walk       out  pedestrian walk lamp
//   phase      out  state code: 0=ALL_RED 1=GREEN 2=YELLOW 3=WALK
module traffic_light_intersection #(
   parameter int CNT_W        = 8,
   parameter int GREEN_TICKS  = 20,
   parameter int YELLOW_TICKS = 4,
   parameter int ALLRED_TICKS = 2,
   parameter int PED_TICKS    = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick_en,
   input  logic       ped_req,
   output logic       ns_red,
   output logic       ns_yellow,
   output logic       ns_green,
   output logic       ew_red,
   output logic       ew_yellow,
   output logic       ew_green,
   output logic       walk,
   output logic [1:0] phase
);

   localparam logic [1:0] S_ALL_RED = 2'd0;
   localparam logic [1:0] S_GREEN   = 2'd1;
   localparam logic [1:0] S_YELLOW  = 2'd2;
   localparam logic [1:0] S_WALK    = 2'd3;

   // Timer reload values: a phase of N ticks counts N-1 down to 0.
   localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_TICKS - 1);
   localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_TICKS - 1);
   localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_TICKS - 1);

   logic [1:0]       state_q, state_d;
   logic             dir_q, dir_d;        // 0 = NS served next/now, 1 = EW
   logic [CNT_W-1:0] timer_q, timer_d;

`ifdef TLC_PED_EN
   localparam logic [CNT_W-1:0] PED_LD = CNT_W'(PED_TICKS - 1);

   logic ped_pending_q, ped_pending_d;
   logic ped_any;

   // A request that arrives in the cycle ALL_RED expires still counts.
   assign ped_any = ped_pending_q | ped_req;
`else
   // Without the pedestrian feature, ped_req and PED_TICKS have no function.
   logic unused_ped;
   assign unused_ped = ped_req ^ (PED_TICKS == 0);
`endif

   //------------------------------------------------------------------
   // Next-state / timer
   //------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      timer_d = timer_q;
      if (tick_en) begin
         if (timer_q != '0) begin
            timer_d = timer_q - 1'b1;
         end else begin
            case (state_q)
               S_ALL_RED: begin
`ifdef TLC_PED_EN
                  if (ped_any) begin
                     state_d = S_WALK;
                     timer_d = PED_LD;
                  end else begin
                     state_d = S_GREEN;
                     timer_d = GREEN_LD;
                  end
`else
                  state_d = S_GREEN;
                  timer_d = GREEN_LD;
`endif
               end
               S_GREEN: begin
                  state_d = S_YELLOW;
                  timer_d = YELLOW_LD;
               end
               S_YELLOW: begin
                  state_d = S_ALL_RED;
                  timer_d = ALLRED_LD;
                  dir_d   = ~dir_q;
               end
               default: begin
                  // WALK resumes the direction that was due; dir unchanged.
                  state_d = S_GREEN;
                  timer_d = GREEN_LD;
               end
            endcase
         end
      end
   end

`ifdef TLC_PED_EN
   // Requests latch every cycle. Entering WALK, or being in it, drops them,
   // so one request yields at most one walk.
   always_comb begin
      ped_pending_d = ped_any;
      if ((state_q == S_WALK) || (state_d == S_WALK))
         ped_pending_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ped_pending_q <= 1'b0;
      else        ped_pending_q <= ped_pending_d;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_ALL_RED;
         dir_q   <= 1'b0;
         timer_q <= ALLRED_LD;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         timer_q <= timer_d;
      end
   end

   //------------------------------------------------------------------
   // Moore lamp decode: reds by default, so exactly one lamp is lit per
   // direction and only the direction in dir can ever show green.
   //------------------------------------------------------------------
   always_comb begin
      ns_red    = 1'b1;
      ns_yellow = 1'b0;
      ns_green  = 1'b0;
      ew_red    = 1'b1;
      ew_yellow = 1'b0;
      ew_green  = 1'b0;
      walk      = 1'b0;
      phase     = state_q;
      case (state_q)
         S_GREEN: begin
            if (!dir_q) begin ns_red = 1'b0; ns_green = 1'b1; end
            else        begin ew_red = 1'b0; ew_green = 1'b1; end
         end
         S_YELLOW: begin
            if (!dir_q) begin ns_red = 1'b0; ns_yellow = 1'b1; end
            else        begin ew_red = 1'b0; ew_yellow = 1'b1; end
         end
`ifdef TLC_PED_EN
         S_WALK:  walk = 1'b1;
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_traffic_light_intersection.sv
// Scoreboard bench for traffic_light_intersection (GREEN=4 YELLOW=2
// ALLRED=1 PED=3). Stimulus pushes the expected lamp vector for each clock;
// a negedge monitor pops and compares, and checks the lamp invariants.
// Expected vector: {ns_r,ns_y,ns_g,ew_r,ew_y,ew_g,walk,phase[1:0]}.
module tb_traffic_light_intersection;

   localparam logic [8:0] E_AR = 9'b100_100_0_00;
   localparam logic [8:0] E_WK = 9'b100_100_1_11;
   localparam logic [8:0] E_GN = 9'b001_100_0_01;
   localparam logic [8:0] E_YN = 9'b010_100_0_10;
   localparam logic [8:0] E_GE = 9'b100_001_0_01;
   localparam logic [8:0] E_YE = 9'b100_010_0_10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       tick_en = 1'b0;
   logic       ped_req = 1'b0;
   logic       ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk;
   logic [1:0] phase;

   logic [8:0] exp_q[$];
   int         n_chk = 0;
   int         n_fail = 0;
   logic       chk_on = 1'b0;

   traffic_light_intersection #(
      .CNT_W(8), .GREEN_TICKS(4), .YELLOW_TICKS(2), .ALLRED_TICKS(1), .PED_TICKS(3)
   ) dut (
      .clk(clk), .rst_n(rst_n), .tick_en(tick_en), .ped_req(ped_req),
      .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
      .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
      .walk(walk), .phase(phase)
   );

   always #5 clk = ~clk;

   // Monitor: outputs are valid every cycle, sampled mid-cycle.
   always @(negedge clk) begin
      if (chk_on) begin
         logic [8:0] act;
         logic [8:0] e;
         act = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, phase};
         n_chk++;
         if ($countones({ns_red, ns_yellow, ns_green}) != 1 ||
             $countones({ew_red, ew_yellow, ew_green}) != 1) begin
            n_fail++;
            $display("FAIL one_lamp t=%0t got %b want one lamp per direction", $time, act);
         end
         n_chk++;
         if (ns_green && ew_green) begin
            n_fail++;
            $display("FAIL dual_green t=%0t got %b want at most one green", $time, act);
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_chk++;
            if (act !== e) begin
               n_fail++;
               $display("FAIL lamps t=%0t got %b want %b", $time, act, e);
            end
         end
      end
   end

   // One clock: apply inputs, record what the outputs must show this cycle.
   task automatic cyc(input logic t, input logic r, input logic [8:0] e);
      tick_en = t;
      ped_req = r;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // A phase lasting 'ticks' strobes, with tick_en on every per-th clock.
   task automatic phase_run(input logic [8:0] e, input int ticks, input int per, input logic r);
      for (int k = 0; k < ticks; k++)
         for (int j = 0; j < per; j++)
            cyc(j == per - 1, r, e);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cyc(1'b1, 1'b0, E_AR);
      cyc(1'b1, 1'b0, E_AR);
      rst_n = 1'b1;
   endtask

   task automatic full_cycle(input int per, input logic r);
      phase_run(E_GN, 4, per, r);
      phase_run(E_YN, 2, per, r);
      phase_run(E_AR, 1, per, r);
      phase_run(E_GE, 4, per, r);
      phase_run(E_YE, 2, per, r);
      phase_run(E_AR, 1, per, r);
   endtask

   initial begin
      @(posedge clk);
      #1;
      chk_on = 1'b1;

      // 1: free-running sequence, 14-clock period, twice around
      do_reset();
      phase_run(E_AR, 1, 1, 1'b0);
      full_cycle(1, 1'b0);
      full_cycle(1, 1'b0);

      // 2: tick_en every 3rd clock stretches every phase 3x
      do_reset();
      phase_run(E_AR, 1, 3, 1'b0);
      full_cycle(3, 1'b0);

      // 3: single request during NS green
      do_reset();
      phase_run(E_AR, 1, 1, 1'b0);
      cyc(1'b1, 1'b1, E_GN);
      phase_run(E_GN, 3, 1, 1'b0);
      phase_run(E_YN, 2, 1, 1'b0);
      phase_run(E_AR, 1, 1, 1'b0);
`ifdef TLC_PED_EN
      phase_run(E_WK, 3, 1, 1'b0);
`endif
      phase_run(E_GE, 4, 1, 1'b0);
      phase_run(E_YE, 2, 1, 1'b0);
      phase_run(E_AR, 1, 1, 1'b0);
      phase_run(E_GN, 4, 1, 1'b0);

      // 4: request in the final ALL_RED cycle; requests during WALK dropped
      do_reset();
      phase_run(E_AR, 1, 1, 1'b1);
`ifdef TLC_PED_EN
      phase_run(E_WK, 3, 1, 1'b1);
`endif
      phase_run(E_GN, 4, 1, 1'b0);
      phase_run(E_YN, 2, 1, 1'b0);
      phase_run(E_AR, 1, 1, 1'b0);
      phase_run(E_GE, 4, 1, 1'b0);

      // 5: reset mid EW yellow aborts at once, restarts with NS
      do_reset();
      phase_run(E_AR, 1, 1, 1'b0);
      phase_run(E_GN, 4, 1, 1'b0);
      phase_run(E_YN, 2, 1, 1'b0);
      phase_run(E_AR, 1, 1, 1'b0);
      phase_run(E_GE, 4, 1, 1'b0);
      cyc(1'b1, 1'b0, E_YE);
      rst_n = 1'b0;
      cyc(1'b1, 1'b0, E_AR);
      rst_n = 1'b1;
      phase_run(E_AR, 1, 1, 1'b0);
      phase_run(E_GN, 4, 1, 1'b0);
      phase_run(E_YN, 2, 1, 1'b0);

`ifndef TLC_PED_EN
      // 6: without the walk feature a held request changes nothing
      do_reset();
      phase_run(E_AR, 1, 1, 1'b1);
      full_cycle(1, 1'b1);
`endif

      tick_en = 1'b0;
      ped_req = 1'b0;
      @(negedge clk);
      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain got %0d pending want 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
